arp_cache_lookup: RTL
=====================

Name: arp_cache_lookup

Overview:
- Responder side of the ARP request/response handshake used by the 33-bit packet scheduler.
- Accepts an IP/port lookup pulse and answers with exactly one pulse: a resolved 48-bit MAC, or a drop indication.
- Holds a small fully associative IP→MAC cache with aging.
- On a miss, it raises ARP requests towards the ARP frame generator and learns replies from the ARP receive parser.

Parameters:
- ENTRIES, 16: cache entries; power of 2; indices 0..ENTRIES-1.
- AGE_MAX, 8'd255: age_tick count after which an idle entry is invalidated.
- TIMEOUT, 16'd50000: clk_net cycles to wait for a reply after each ARP request.
- RETRY_MAX, 2'd2: extra requests issued after the first before giving up. Total requests = RETRY_MAX+1.

Ports:
- clk_net input 1: single clock for the whole block.
- rst_n input 1: reset, asynchronous, active-low.
- arp_ip_din input 32: IP address to resolve.
- arp_port_num_din input 4: network port of the lookup.
- arp_din_en input 1: one-cycle lookup strobe; arp_ip_din and arp_port_num_din are valid with it.
- arp_mac_dout output 48: resolved MAC; valid with arp_mac_dout_en.
- arp_mac_dout_en output 1: one-cycle hit/resolved pulse.
- arp_del_dout_en output 1: one-cycle unresolved pulse; the requester discards the packet.
- arp_req_ip output 32: IP for the ARP frame generator.
- arp_req_port output 4: port for the ARP frame generator.
- arp_req_en output 1: one-cycle ARP request strobe.
- learn_ip input 32: sender IP from a received ARP reply.
- learn_mac input 48: sender MAC from a received ARP reply.
- learn_port input 4: port the reply arrived on.
- learn_en input 1: one-cycle learn strobe.
- age_tick input 1: one-cycle aging pulse (about 1 s).
- busy output 1: high whenever the state is not IDLE.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - all outputs 0;
  - all entries invalid, ages 0;
  - repl_ptr 0;
  - state IDLE;
  - effective immediately, including mid-lookup. No response pulse is emitted for an aborted lookup.
- All outputs are registered. arp_mac_dout holds its last value between pulses; it is 0 after reset.
- Entry contents: valid, ip[31:0], port[3:0], mac[47:0], age[7:0].
- Hit condition: valid && ip==key_ip && port==key_port.
- FSM states:
  - IDLE: on arp_din_en, latch key_ip/key_port, set idx=0, go to SCAN. A strobe in any other state is ignored (no response); busy is high.
  - SCAN: compare entry[idx], one per cycle.
    - Hit → HIT; entry age cleared to 0.
    - idx==ENTRIES-1 with no hit → REQ.
    - A learn_en matching key_ip/key_port in SCAN → HIT using learn_mac; this has priority over the scan compare.
  - REQ: pulse arp_req_en with key_ip/key_port for one cycle, clear the timer, go to WAIT.
  - WAIT: timer increments each cycle.
    - learn_en matching the key → HIT with learn_mac.
    - Timer reaches TIMEOUT-1: if retries < RETRY_MAX, increment retries and go to REQ; else go to MISS.
  - HIT: arp_mac_dout_en=1 and arp_mac_dout=MAC for one cycle; go to IDLE.
  - MISS: arp_del_dout_en=1 for one cycle; go to IDLE.
- Latency:
  - A hit at entry k, strobe at cycle T: arp_mac_dout_en is at T+k+3 (latch T+1, compare T+k+1, HIT state T+k+2 drives the registered output).
  - A full miss: arp_req_en first at T+ENTRIES+2.
- arp_mac_dout_en and arp_del_dout_en are never high together. Exactly one of them occurs per accepted lookup.
- Learn (any state, every cycle learn_en=1), write target in priority order:
  - the entry matching learn_ip/learn_port;
  - otherwise the lowest-index invalid entry;
  - otherwise entry[repl_ptr], then repl_ptr = (repl_ptr+1) mod ENTRIES.
  - The written entry gets valid=1, mac updated, age=0.
  - The write is visible to SCAN compares from the next cycle.
- Aging: on age_tick, every valid entry with age==AGE_MAX is invalidated; others do age+1.
  - learn_en and age_tick on the same entry in the same cycle: learn wins (valid=1, age=0).
  - A hit and age_tick on the same entry: age=0.
- learn_ip=0 is written like any other IP. No special cases.

Test Plan:
- Learn ip=0xC0A80102, port=3, mac=0x001122334455; then lookup the same ip/port → no arp_req_en; arp_mac_dout_en=1 with arp_mac_dout=0x001122334455, 3 cycles after the strobe (entry 0).
- Lookup ip=0xC0A80105, port=1 on an empty cache → arp_req_en at T+18 with arp_req_ip=0xC0A80105; learn_en with the matching ip/port and mac=0xAABBCCDDEEFF 100 cycles later → arp_mac_dout_en, MAC 0xAABBCCDDEEFF.
- Lookup on an empty cache with no reply → three arp_req_en pulses spaced TIMEOUT+1 cycles apart, then a single arp_del_dout_en; arp_mac_dout_en never asserted.
- Fill 16 entries (ips 1..16), then learn ip 17 → entry 0 replaced; lookup ip 1 → arp_req_en issued (miss); lookup ip 2 → hit.
- Learn an entry, apply 256 age_tick pulses → lookup misses; with a hit between ticks 100 and 101, the lookup after 256 ticks still hits.
- Deassert rst_n during WAIT → outputs 0 immediately; no response pulse; the next lookup of the previously learned ip misses.

Source files
------------

// File: rtl/arp_cache_lookup.sv
// ARP cache responder: fully associative IP/port -> MAC cache with aging,
// sequential scan on lookup, ARP request/retry on miss and learning from replies.
`default_nettype none

module arp_cache_lookup #(
  parameter int          ENTRIES   = 16,
  parameter logic [7:0]  AGE_MAX   = 8'd255,
  parameter logic [15:0] TIMEOUT   = 16'd50000,
  parameter logic [1:0]  RETRY_MAX = 2'd2
) (
  input  logic        clk_net,
  input  logic        rst_n,
  input  logic [31:0] arp_ip_din,
  input  logic [3:0]  arp_port_num_din,
  input  logic        arp_din_en,
  output logic [47:0] arp_mac_dout,
  output logic        arp_mac_dout_en,
  output logic        arp_del_dout_en,
  output logic [31:0] arp_req_ip,
  output logic [3:0]  arp_req_port,
  output logic        arp_req_en,
  input  logic [31:0] learn_ip,
  input  logic [47:0] learn_mac,
  input  logic [3:0]  learn_port,
  input  logic        learn_en,
  input  logic        age_tick,
  output logic        busy
);

  localparam int IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(ENTRIES - 1);

  typedef enum logic [2:0] {IDLE, SCAN, REQ, WAIT, HIT, MISS} state_t;
  state_t state, next_state;

  logic [ENTRIES-1:0] ent_valid;
  logic [31:0]        ent_ip   [ENTRIES];
  logic [3:0]         ent_port [ENTRIES];
  logic [47:0]        ent_mac  [ENTRIES];
  logic [7:0]         ent_age  [ENTRIES];
  logic [IW-1:0]      repl_ptr;

  logic [31:0]   key_ip;
  logic [3:0]    key_port;
  logic [IW-1:0] idx;
  logic [15:0]   timer;
  logic [1:0]    retries;
  logic [47:0]   res_mac;

  logic          learn_key, scan_hit, scan_hit_clr, timer_done;
  logic          match_found, free_found, use_repl;
  logic [IW-1:0] match_idx, free_idx, tgt_idx;

  assign learn_key    = learn_en && (learn_ip == key_ip) && (learn_port == key_port);
  assign scan_hit     = ent_valid[idx] && (ent_ip[idx] == key_ip) && (ent_port[idx] == key_port);
  assign scan_hit_clr = (state == SCAN) && !learn_key && scan_hit;
  assign timer_done   = (timer == TIMEOUT - 16'd1);

  // Learn target: existing match, else lowest free slot, else round-robin victim.
  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    free_found  = 1'b0;
    free_idx    = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (ent_valid[i] && ent_ip[i] == learn_ip && ent_port[i] == learn_port) begin
        match_found = 1'b1;
        match_idx   = IW'(i);
      end
      if (!ent_valid[i]) begin
        free_found = 1'b1;
        free_idx   = IW'(i);
      end
    end
    use_repl = !match_found && !free_found;
    if (match_found)     tgt_idx = match_idx;
    else if (free_found) tgt_idx = free_idx;
    else                 tgt_idx = repl_ptr;
  end

  always_ff @(posedge clk_net or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ent_valid[i] <= 1'b0;
        ent_ip[i]    <= '0;
        ent_port[i]  <= '0;
        ent_mac[i]   <= '0;
        ent_age[i]   <= '0;
      end
      repl_ptr <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (learn_en && tgt_idx == IW'(i)) begin
          ent_valid[i] <= 1'b1;
          ent_ip[i]    <= learn_ip;
          ent_port[i]  <= learn_port;
          ent_mac[i]   <= learn_mac;
          ent_age[i]   <= '0;
        end else if (scan_hit_clr && idx == IW'(i)) begin
          ent_age[i] <= '0;
        end else if (age_tick && ent_valid[i]) begin
          if (ent_age[i] == AGE_MAX) ent_valid[i] <= 1'b0;
          else                       ent_age[i]   <= ent_age[i] + 8'd1;
        end
      end
      if (learn_en && use_repl) repl_ptr <= repl_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_net or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (arp_din_en) next_state = SCAN;
      SCAN: begin
        if (learn_key || scan_hit) next_state = HIT;
        else if (idx == LAST_IDX)  next_state = REQ;
      end
      REQ:  next_state = WAIT;
      WAIT: begin
        if (learn_key)       next_state = HIT;
        else if (timer_done) next_state = (retries < RETRY_MAX) ? REQ : MISS;
      end
      HIT, MISS: next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_net or negedge rst_n) begin
    if (!rst_n) begin
      key_ip          <= '0;
      key_port        <= '0;
      idx             <= '0;
      timer           <= '0;
      retries         <= '0;
      res_mac         <= '0;
      arp_mac_dout    <= '0;
      arp_mac_dout_en <= 1'b0;
      arp_del_dout_en <= 1'b0;
      arp_req_ip      <= '0;
      arp_req_port    <= '0;
      arp_req_en      <= 1'b0;
      busy            <= 1'b0;
    end else begin
      case (state)
        IDLE: if (arp_din_en) begin
          key_ip   <= arp_ip_din;
          key_port <= arp_port_num_din;
          idx      <= '0;
          retries  <= '0;
        end
        SCAN: begin
          if (learn_key)     res_mac <= learn_mac;
          else if (scan_hit) res_mac <= ent_mac[idx];
          else               idx     <= idx + 1'b1;
        end
        REQ:  timer <= '0;
        WAIT: begin
          timer <= timer + 16'd1;
          if (learn_key) res_mac <= learn_mac;
          else if (timer_done && retries < RETRY_MAX) retries <= retries + 2'd1;
        end
        default: ;
      endcase

      arp_mac_dout_en <= (state == HIT);
      arp_del_dout_en <= (state == MISS);
      arp_req_en      <= (state == REQ);
      busy            <= (next_state != IDLE);
      if (state == HIT) arp_mac_dout <= res_mac;
      if (state == REQ) begin
        arp_req_ip   <= key_ip;
        arp_req_port <= key_port;
      end
    end
  end

endmodule

`default_nettype wire
